// File: rtl/iter_shifter_if.sv
// Request/response bundle for the iterative shifter.
// The shift-type field is called op_type because "type" is a reserved word.
interface iter_shifter_if #(
  parameter int unsigned XLEN = 32
);
  localparam int unsigned SHW = $clog2(XLEN);

  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] a;
  logic [SHW-1:0]  shamt;
  logic [1:0]      op_type;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] r;
  logic            busy;

  modport master (
    output flush, in_valid, a, shamt, op_type, out_ready,
    input  in_ready, out_valid, r, busy
  );

  modport slave (
    input  flush, in_valid, a, shamt, op_type, out_ready,
    output in_ready, out_valid, r, busy
  );
endinterface

// File: rtl/iter_shifter.sv
// Multi-cycle shifter: SLL/SRL/SRA/ROR, at most STEP bit positions per BUSY cycle.
// One operation in flight; valid/ready on both sides; synchronous flush.
module iter_shifter #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned STEP = 4
) (
  input logic           clk,
  input logic           rst_n,
  iter_shifter_if.slave bus
);
  localparam int unsigned SHW = $clog2(XLEN);

  localparam logic [1:0] TySll = 2'b00;
  localparam logic [1:0] TySrl = 2'b01;
  localparam logic [1:0] TySra = 2'b11;

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] data_q, data_d;
  logic [SHW-1:0]  rem_q, rem_d;
  logic [1:0]      type_q, type_d;
  logic            sign_q, sign_d;

  logic [XLEN-1:0] step_res;
  logic [SHW:0]    k;
  logic [SHW-1:0]  rem_nxt;
  logic            accept;

  assign accept = (state_q == StIdle) && bus.in_valid && !bus.flush;

  // Per-step shift distance k = min(STEP, rem); one bit wider so STEP == XLEN fits.
  always_comb begin
    k = {1'b0, rem_q};
    if (k > (SHW+1)'(STEP)) k = (SHW+1)'(STEP);
  end

  // k never exceeds rem, so the truncation to SHW bits is lossless.
  assign rem_nxt = rem_q - k[SHW-1:0];

  // Small mux of constant shifts by 1..STEP instead of a full barrel shifter.
  always_comb begin
    step_res = data_q;
    for (int unsigned j = 1; j <= STEP; j++) begin
      if (k == (SHW+1)'(j)) begin
        case (type_q)
          TySll:   step_res = data_q << j;
          TySrl:   step_res = data_q >> j;
          TySra:   step_res = (data_q >> j) | (sign_q ? ~({XLEN{1'b1}} >> j) : '0);
          default: step_res = (data_q >> j) | (data_q << (XLEN - j));
        endcase
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state; flush beats both accept and consume.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (accept) state_d = (bus.shamt == '0) ? StDone : StBusy;
      end
      StBusy: begin
        if (bus.flush)          state_d = StIdle;
        else if (rem_nxt == '0) state_d = StDone;
      end
      StDone: begin
        if (bus.flush || bus.out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs; r is forced to zero outside DONE.
  always_comb begin
    bus.in_ready  = (state_q == StIdle);
    bus.out_valid = (state_q == StDone);
    bus.busy      = (state_q != StIdle);
    bus.r         = (state_q == StDone) ? data_q : '0;
  end

  // Datapath next state: load on accept, step while BUSY.
  always_comb begin
    data_d = data_q;
    rem_d  = rem_q;
    type_d = type_q;
    sign_d = sign_q;
    if (accept) begin
      data_d = bus.a;
      rem_d  = bus.shamt;
      type_d = bus.op_type;
      sign_d = bus.a[XLEN-1];
    end else if (state_q == StBusy && !bus.flush) begin
      data_d = step_res;
      rem_d  = rem_nxt;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      rem_q  <= '0;
      type_q <= '0;
      sign_q <= 1'b0;
    end else begin
      data_q <= data_d;
      rem_q  <= rem_d;
      type_q <= type_d;
      sign_q <= sign_d;
    end
  end

endmodule

// File: tb/tb_iter_shifter.sv
// Self-checking bench for iter_shifter (XLEN=32, STEP=4).
module tb_iter_shifter;
  logic clk;
  logic rst_n;

  iter_shifter_if #(.XLEN(32)) bus ();

  iter_shifter #(.XLEN(32), .STEP(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] sb[$];

  typedef struct {
    logic [31:0] a;
    logic [4:0]  sh;
    logic [1:0]  ty;
    logic [31:0] exp_r;
    int          lat;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, got, exp);
    end
  endtask

  // Reference: one full-width shift.
  function automatic logic [31:0] model(input logic [31:0] av, input logic [4:0] sv,
                                        input logic [1:0] tv);
    logic [63:0] dbl;
    dbl = {av, av} >> sv;
    case (tv)
      2'b00:   return av << sv;
      2'b01:   return av >> sv;
      2'b11:   return 32'($signed(av) >>> sv);
      default: return dbl[31:0];
    endcase
  endfunction

  function automatic int lat_of(input logic [4:0] sv);
    return (sv == 0) ? 1 : 1 + (int'(sv) + 3) / 4;
  endfunction

  // Issue one request (called #1 after a posedge in IDLE), check latency and result, consume.
  task automatic run_op(input logic [31:0] av, input logic [4:0] sv, input logic [1:0] tv,
                        input logic [31:0] er, input int el, input string nm);
    int cyc;
    logic [31:0] exp_r;
    chk({nm, " in_ready"}, 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.a        = av;
    bus.shamt    = sv;
    bus.op_type  = tv;
    sb.push_back(er);
    @(posedge clk); #1;
    // Scramble inputs: only the accept edge may matter.
    bus.in_valid = 1'b0;
    bus.a        = $urandom;
    bus.shamt    = 5'($urandom);
    bus.op_type  = 2'($urandom);
    if (sv != 0) chk({nm, " r_zero_busy"}, bus.r, 32'd0);
    cyc = 1;
    while (!bus.out_valid && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk({nm, " latency"}, 32'(cyc), 32'(el));
    if (bus.out_valid) begin
      exp_r = sb.pop_front();
      chk({nm, " r"}, bus.r, exp_r);
      chk({nm, " in_ready_done"}, 32'(bus.in_ready), 32'd0);
    end else begin
      void'(sb.pop_front());
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk({nm, " consumed"}, 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int cyc;
    logic [31:0] held_r;
    logic saw_valid;
    logic [31:0] ra;
    logic [4:0] rs;
    logic [1:0] rt;

    vecs[0]  = '{32'h0000_0001, 5'd31, 2'b00, 32'h8000_0000, 9};
    vecs[1]  = '{32'h8000_0000, 5'd4,  2'b11, 32'hF800_0000, 2};
    vecs[2]  = '{32'h8000_0000, 5'd4,  2'b01, 32'h0800_0000, 2};
    vecs[3]  = '{32'h1234_5678, 5'd8,  2'b10, 32'h7812_3456, 3};
    vecs[4]  = '{32'hDEAD_BEEF, 5'd0,  2'b00, 32'hDEAD_BEEF, 1};
    vecs[5]  = '{32'hDEAD_BEEF, 5'd0,  2'b10, 32'hDEAD_BEEF, 1};
    vecs[6]  = '{32'h8000_0001, 5'd31, 2'b11, 32'hFFFF_FFFF, 9};
    vecs[7]  = '{32'hFFFF_FFFF, 5'd5,  2'b01, 32'h07FF_FFFF, 3};
    vecs[8]  = '{32'h0000_0001, 5'd1,  2'b10, 32'h8000_0000, 2};
    vecs[9]  = '{32'h7FFF_FFF0, 5'd4,  2'b11, 32'h07FF_FFFF, 2};
    vecs[10] = '{32'h0000_000F, 5'd7,  2'b00, 32'h0000_0780, 3};
    vecs[11] = '{32'h8000_0001, 5'd31, 2'b10, 32'h0000_0003, 9};

    rst_n         = 1'b0;
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.shamt     = '0;
    bus.op_type   = '0;
    bus.out_ready = 1'b0;

    // Reset values
    #12;
    chk("rst in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst busy", 32'(bus.busy), 32'd0);
    chk("rst r", bus.r, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed vectors
    for (int i = 0; i < 12; i++)
      run_op(vecs[i].a, vecs[i].sh, vecs[i].ty, vecs[i].exp_r, vecs[i].lat,
             $sformatf("vec%0d", i));

    // Backpressure: 5 stalled cycles in DONE, then consume with in_valid held high
    bus.in_valid = 1'b1; bus.a = 32'h1; bus.shamt = 5'd4; bus.op_type = 2'b00;
    sb.push_back(32'h10);
    @(posedge clk); #1;
    cyc = 1;
    while (!bus.out_valid && cyc < 40) begin @(posedge clk); #1; cyc++; end
    chk("bp latency", 32'(cyc), 32'd2);
    held_r = sb.pop_front();
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp r%0d", i), bus.r, held_r);
      chk($sformatf("bp valid%0d", i), 32'(bus.out_valid), 32'd1);
      chk($sformatf("bp in_ready%0d", i), 32'(bus.in_ready), 32'd0);
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk("bp consume idle", 32'(bus.busy), 32'd0);
    chk("bp consume in_ready", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b0;

    // Flush in the 2nd BUSY cycle
    bus.in_valid = 1'b1; bus.a = 32'h1; bus.shamt = 5'd12; bus.op_type = 2'b00;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    chk("flush busy", 32'(bus.busy), 32'd0);
    chk("flush in_ready", 32'(bus.in_ready), 32'd1);
    saw_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      saw_valid |= bus.out_valid;
      @(posedge clk); #1;
    end
    chk("flush no valid", 32'(saw_valid), 32'd0);
    run_op(32'hA5A5_0F0F, 5'd13, 2'b10, model(32'hA5A5_0F0F, 5'd13, 2'b10), 5, "post_flush");

    // Flush in IDLE blocks the request
    bus.in_valid = 1'b1; bus.flush = 1'b1; bus.shamt = 5'd3;
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.flush = 1'b0;
    chk("idle flush busy", 32'(bus.busy), 32'd0);

    // Flush in DONE beats consume
    bus.in_valid = 1'b1; bus.a = 32'h55; bus.shamt = 5'd0; bus.op_type = 2'b01;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk("done pre flush valid", 32'(bus.out_valid), 32'd1);
    bus.flush = 1'b1; bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0; bus.out_ready = 1'b0;
    chk("done flush valid", 32'(bus.out_valid), 32'd0);
    chk("done flush r", bus.r, 32'd0);

    // Async reset mid-BUSY, off-edge
    bus.in_valid = 1'b1; bus.a = 32'hFFFF_0000; bus.shamt = 5'd31; bus.op_type = 2'b11;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("arst busy", 32'(bus.busy), 32'd0);
    chk("arst in_ready", 32'(bus.in_ready), 32'd1);
    chk("arst out_valid", 32'(bus.out_valid), 32'd0);
    chk("arst r", bus.r, 32'd0);
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("arst still idle", 32'(bus.busy), 32'd0);

    // Random vs single-shift model
    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      rs = 5'($urandom_range(0, 31));
      rt = 2'($urandom_range(0, 3));
      run_op(ra, rs, rt, model(ra, rs, rt), lat_of(rs), $sformatf("rand%0d", i));
    end

    chk("sb empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
